// File: rtl/xif_issue_queue.sv
// CV-X-IF issue queue: claims accelerator instructions, gathers operands and
// commit/kill status, and dispatches committed entries in program order.
module xif_issue_queue #(
  parameter logic [6:0]  OPCODE   = 7'h2B,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [31:0]                issue_instr_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  output logic                       issue_accept_o,
  output logic                       issue_writeback_o,
  input  logic                       register_valid_i,
  output logic                       register_ready_o,
  input  logic [ID_WIDTH-1:0]        register_id_i,
  input  logic [2*XLEN-1:0]          register_rs_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       dispatch_valid_o,
  input  logic                       dispatch_ready_i,
  output logic [31:0]                dispatch_instr_o,
  output logic [ID_WIDTH-1:0]        dispatch_id_o,
  output logic [XLEN-1:0]            dispatch_rs1_o,
  output logic [XLEN-1:0]            dispatch_rs2_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    ops_ok_q, ops_ok_d;
  logic [DEPTH-1:0]    committed_q, committed_d;
  logic [DEPTH-1:0]    killed_q, killed_d;
  logic [31:0]         instr_q [DEPTH];
  logic [31:0]         instr_d [DEPTH];
  logic [ID_WIDTH-1:0] id_q    [DEPTH];
  logic [ID_WIDTH-1:0] id_d    [DEPTH];
  logic [XLEN-1:0]     rs1_q   [DEPTH];
  logic [XLEN-1:0]     rs1_d   [DEPTH];
  logic [XLEN-1:0]     rs2_q   [DEPTH];
  logic [XLEN-1:0]     rs2_d   [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic alloc;
  logic kill_free;
  logic disp_fire;
  logic free;

  assign issue_ready_o     = (count_q < CW'(DEPTH));
  assign issue_accept_o    = (issue_instr_i[6:0] == OPCODE);
  assign issue_writeback_o = 1'b0;
  assign register_ready_o  = 1'b1;

  assign dispatch_valid_o  = valid_q[rd_ptr_q] & committed_q[rd_ptr_q] &
                             ~killed_q[rd_ptr_q] & ops_ok_q[rd_ptr_q];
  assign dispatch_instr_o  = instr_q[rd_ptr_q];
  assign dispatch_id_o     = id_q[rd_ptr_q];
  assign dispatch_rs1_o    = rs1_q[rd_ptr_q];
  assign dispatch_rs2_o    = rs2_q[rd_ptr_q];
  assign count_o           = count_q;

  assign alloc     = issue_valid_i & issue_ready_o & issue_accept_o;
  assign kill_free = valid_q[rd_ptr_q] & committed_q[rd_ptr_q] & killed_q[rd_ptr_q];
  assign disp_fire = dispatch_valid_o & dispatch_ready_i;
  assign free      = kill_free | disp_fire;

  // Next state: allocate, then apply operands and commit so same-cycle events
  // reach a freshly allocated entry; freeing the head is applied last.
  always_comb begin
    valid_d     = valid_q;
    ops_ok_d    = ops_ok_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    instr_d     = instr_q;
    id_d        = id_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (alloc) begin
      valid_d[wr_ptr_q]     = 1'b1;
      ops_ok_d[wr_ptr_q]    = 1'b0;
      committed_d[wr_ptr_q] = 1'b0;
      killed_d[wr_ptr_q]    = 1'b0;
      instr_d[wr_ptr_q]     = issue_instr_i;
      id_d[wr_ptr_q]        = issue_id_i;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (register_valid_i && valid_d[i] && !killed_d[i] && (id_d[i] == register_id_i)) begin
        rs1_d[i]    = register_rs_i[XLEN-1:0];
        rs2_d[i]    = register_rs_i[2*XLEN-1:XLEN];
        ops_ok_d[i] = 1'b1;
      end
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (commit_valid_i && valid_d[i] && (id_d[i] == commit_id_i)) begin
        committed_d[i] = 1'b1;
        if (commit_kill_i) begin
          killed_d[i] = 1'b1;
        end
      end
    end

    if (free) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end

    if (alloc && !free) begin
      count_d = count_q + CW'(1);
    end else if (free && !alloc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      ops_ok_q    <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      ops_ok_q    <= ops_ok_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= instr_d[i];
        id_q[i]    <= id_d[i];
        rs1_q[i]   <= rs1_d[i];
        rs2_q[i]   <= rs2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_xif_issue_queue.sv
// Directed bench for xif_issue_queue: flow, filtering, full, kill, reordering, reset.
module tb_xif_issue_queue;

  localparam int unsigned ID_WIDTH = 4;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic                issue_accept_o;
  logic                issue_writeback_o;
  logic                register_valid_i;
  logic                register_ready_o;
  logic [ID_WIDTH-1:0] register_id_i;
  logic [2*XLEN-1:0]   register_rs_i;
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  logic                dispatch_valid_o;
  logic                dispatch_ready_i;
  logic [31:0]         dispatch_instr_o;
  logic [ID_WIDTH-1:0] dispatch_id_o;
  logic [XLEN-1:0]     dispatch_rs1_o;
  logic [XLEN-1:0]     dispatch_rs2_o;
  logic [2:0]          count_o;

  int errors = 0;
  int checks = 0;
  logic [ID_WIDTH-1:0] disp_ids[$];
  logic [XLEN-1:0]     disp_rs1[$];

  xif_issue_queue #(.OPCODE(7'h2B), .ID_WIDTH(ID_WIDTH), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
    .register_id_i(register_id_i), .register_rs_i(register_rs_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .dispatch_valid_o(dispatch_valid_o), .dispatch_ready_i(dispatch_ready_i),
    .dispatch_instr_o(dispatch_instr_o), .dispatch_id_o(dispatch_id_o),
    .dispatch_rs1_o(dispatch_rs1_o), .dispatch_rs2_o(dispatch_rs2_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Record every dispatch handshake mid-cycle.
  always @(negedge clk) begin
    if (rst_n && dispatch_valid_o && dispatch_ready_i) begin
      disp_ids.push_back(dispatch_id_o);
      disp_rs1.push_back(dispatch_rs1_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    register_valid_i = 1'b0;
    register_id_i    = '0;
    register_rs_i    = '0;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] instr);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    issue_instr_i = instr;
  endtask

  task automatic regs(input logic [3:0] id, input logic [31:0] rs1, input logic [31:0] rs2);
    register_valid_i = 1'b1;
    register_id_i    = id;
    register_rs_i    = {rs2, rs1};
  endtask

  task automatic cmt(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic check_order(input string tag, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g0, g1;
    g0 = (disp_ids.size() > 0) ? disp_ids[0] : 4'hF;
    g1 = (disp_ids.size() > 1) ? disp_ids[1] : 4'hF;
    check({tag, "_n"}, 64'(disp_ids.size()), 64'd2);
    check({tag, "_0"}, 64'(g0), 64'(a));
    check({tag, "_1"}, 64'(g1), 64'(b));
  endtask

  initial begin
    rst_n = 1'b0;
    dispatch_ready_i = 1'b0;
    clr();
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(issue_ready_o), 64'd1);
    check("rst_dv", 64'(dispatch_valid_o), 64'd0);
    check("rst_accept", 64'(issue_accept_o), 64'd0);
    check("rst_id", 64'(dispatch_id_o), 64'd0);
    check("rst_rs1", 64'(dispatch_rs1_o), 64'd0);
    check("const_wb", 64'(issue_writeback_o), 64'd0);
    check("const_regrdy", 64'(register_ready_o), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back flow
    issue(4'd1, 32'h0000_002B); regs(4'd1, 32'h11, 32'h22); cmt(4'd1, 1'b0);
    dispatch_ready_i = 1'b1;
    #1 check("b2b_accept", 64'(issue_accept_o), 64'd1);
    tick(); clr();
    check("b2b_dv", 64'(dispatch_valid_o), 64'd1);
    check("b2b_id", 64'(dispatch_id_o), 64'd1);
    check("b2b_rs1", 64'(dispatch_rs1_o), 64'h11);
    check("b2b_rs2", 64'(dispatch_rs2_o), 64'h22);
    check("b2b_instr", 64'(dispatch_instr_o), 64'h2B);
    check("b2b_cnt1", 64'(count_o), 64'd1);
    tick();
    check("b2b_cnt0", 64'(count_o), 64'd0);
    check("b2b_dv0", 64'(dispatch_valid_o), 64'd0);
    dispatch_ready_i = 1'b0;

    // Opcode filter
    issue(4'd5, 32'h0000_0033);
    #1 check("flt_accept", 64'(issue_accept_o), 64'd0);
    check("flt_ready", 64'(issue_ready_o), 64'd1);
    tick(); clr();
    check("flt_cnt", 64'(count_o), 64'd0);
    check("flt_dv", 64'(dispatch_valid_o), 64'd0);

    // Full queue
    for (int i = 1; i <= 4; i++) begin
      issue(4'(i), 32'h0000_002B | (32'(i) << 12));
      tick();
    end
    clr();
    check("full_cnt", 64'(count_o), 64'd4);
    check("full_ready", 64'(issue_ready_o), 64'd0);
    issue(4'd6, 32'h0000_602B);
    tick();
    check("full_stall_cnt", 64'(count_o), 64'd4);
    regs(4'd1, 32'hA1, 32'hA2); cmt(4'd1, 1'b0);
    tick();
    register_valid_i = 1'b0; commit_valid_i = 1'b0;
    check("full_head_dv", 64'(dispatch_valid_o), 64'd1);
    check("full_head_id", 64'(dispatch_id_o), 64'd1);
    check("full_noby", 64'(issue_ready_o), 64'd0);
    dispatch_ready_i = 1'b1;
    tick();
    dispatch_ready_i = 1'b0;
    check("full_ready_back", 64'(issue_ready_o), 64'd1);
    check("full_cnt3", 64'(count_o), 64'd3);
    tick();
    clr();
    check("full_cnt_refill", 64'(count_o), 64'd4);
    cmt(4'd2, 1'b1); tick();
    cmt(4'd3, 1'b1); tick();
    cmt(4'd4, 1'b1); tick();
    cmt(4'd6, 1'b1); tick();
    clr();
    check("drain_dv", 64'(dispatch_valid_o), 64'd0);
    tick(); tick();
    check("drain_cnt", 64'(count_o), 64'd0);

    // Kill in the middle
    disp_ids.delete(); disp_rs1.delete();
    for (int i = 2; i <= 4; i++) begin
      issue(4'(i), 32'h0000_002B);
      regs(4'(i), 32'(i) << 8, (32'(i) << 8) | 32'h1);
      tick();
    end
    clr();
    dispatch_ready_i = 1'b1;
    cmt(4'd2, 1'b0); tick();
    cmt(4'd3, 1'b1); tick();
    cmt(4'd4, 1'b0); tick();
    clr();
    for (int i = 0; i < 4; i++) tick();
    check_order("kill_order", 4'd2, 4'd4);
    check("kill_rs1_4", 64'((disp_rs1.size() > 1) ? disp_rs1[1] : 32'hFFFF_FFFF), 64'h400);
    check("kill_cnt", 64'(count_o), 64'd0);
    dispatch_ready_i = 1'b0;

    // Out-of-order operands and commits
    disp_ids.delete(); disp_rs1.delete();
    issue(4'd3, 32'h0000_302B); tick();
    issue(4'd4, 32'h0000_402B); tick();
    clr();
    regs(4'd4, 32'h44, 32'h45); tick();
    regs(4'd3, 32'h33, 32'h34); tick();
    clr();
    cmt(4'd3, 1'b0); tick();
    cmt(4'd4, 1'b0); tick();
    clr();
    for (int i = 0; i < 3; i++) begin
      check("ooo_hold_dv", 64'(dispatch_valid_o), 64'd1);
      check("ooo_hold_id", 64'(dispatch_id_o), 64'd3);
      check("ooo_hold_rs", {32'(dispatch_rs2_o), 32'(dispatch_rs1_o)}, 64'h0000_0034_0000_0033);
      check("ooo_hold_in", 64'(dispatch_instr_o), 64'h302B);
      tick();
    end
    dispatch_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dispatch_ready_i = 1'b0;
    check_order("ooo_order", 4'd3, 4'd4);
    check("ooo_cnt", 64'(count_o), 64'd0);

    // Asynchronous reset with 3 live entries
    issue(4'd7, 32'h0000_002B); regs(4'd7, 32'h77, 32'h78); cmt(4'd7, 1'b0); tick();
    clr();
    issue(4'd8, 32'h0000_002B); tick();
    issue(4'd9, 32'h0000_002B); tick();
    clr();
    check("ar_pre_cnt", 64'(count_o), 64'd3);
    check("ar_pre_dv", 64'(dispatch_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cnt", 64'(count_o), 64'd0);
    check("ar_dv", 64'(dispatch_valid_o), 64'd0);
    check("ar_ready", 64'(issue_ready_o), 64'd1);
    check("ar_id", 64'(dispatch_id_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
